// File: rtl/line_window_3x3.sv
// Raster pixel stream to 3x3 neighbourhood windows through two line buffers.
// Optional in_sof framing input is enabled by defining LINE_WINDOW_SOF_EN.
module line_window_3x3 #(
   parameter int DATA_W       = 8,
   parameter int LINE_WIDTH   = 72,
   parameter int FRAME_HEIGHT = 72,
   parameter int COL_W        = 7
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_pixel,
`ifdef LINE_WINDOW_SOF_EN
   input  logic                in_sof,
`endif
   output logic                out_valid,
   input  logic                out_ready,
   output logic [9*DATA_W-1:0] out_win,
   output logic [COL_W-1:0]    out_col,
   output logic [COL_W-1:0]    out_row,
   output logic                out_last
);

   typedef enum logic {FILL, RUN} state_t;

   localparam int AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(LINE_WIDTH - 1);
   localparam logic [COL_W-1:0] ROW_MAX = COL_W'(FRAME_HEIGHT - 1);
   localparam logic [COL_W-1:0] TWO     = COL_W'(2);
   localparam logic [COL_W-1:0] ONE     = COL_W'(1);

   logic [DATA_W-1:0]   lb0 [LINE_WIDTH];
   logic [DATA_W-1:0]   lb1 [LINE_WIDTH];
   logic [DATA_W-1:0]   rd0, rd1, s1_pixel;
   logic [COL_W-1:0]    col, row, cur_col, cur_row;
   logic [COL_W-1:0]    s1_col, s1_row;
   logic                s1_full, s1_emit, s1_last;
   logic                s1_adv, in_xfer, sof;
   logic [9*DATA_W-1:0] win_next;
   state_t              state, st_now;

`ifdef LINE_WINDOW_SOF_EN
   assign sof = in_sof;
`else
   assign sof = 1'b0;
`endif

   assign s1_adv   = s1_full & (~out_valid | out_ready);
   assign in_ready = ~reset & (~s1_full | s1_adv);
   assign in_xfer  = in_valid & in_ready;

   // A start-of-frame pixel is placed at (0,0) regardless of the counters
   assign cur_col = sof ? '0 : col;
   assign cur_row = sof ? '0 : row;

   always_comb begin
      st_now = state;
      if (sof)
         st_now = FILL;
      else if (row == TWO && col == '0)
         st_now = RUN;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col      <= '0;
         row      <= '0;
         state    <= FILL;
         s1_full  <= 1'b0;
         s1_emit  <= 1'b0;
         s1_last  <= 1'b0;
         s1_pixel <= '0;
         s1_col   <= '0;
         s1_row   <= '0;
      end else begin
         if (in_xfer) begin
            s1_full  <= 1'b1;
            s1_pixel <= in_pixel;
            s1_col   <= cur_col;
            s1_row   <= cur_row;
            s1_emit  <= (st_now == RUN) && (cur_col >= TWO);
            s1_last  <= (cur_row == ROW_MAX) && (cur_col == COL_MAX);
            if (cur_col == COL_MAX) begin
               col <= '0;
               row <= (cur_row == ROW_MAX) ? '0 : cur_row + ONE;
            end else begin
               col <= cur_col + ONE;
               row <= cur_row;
            end
            if (cur_row == ROW_MAX && cur_col == COL_MAX)
               state <= FILL;
            else
               state <= st_now;
         end else if (s1_adv) begin
            s1_full <= 1'b0;
         end
      end
   end

   // Line buffers: read old row data at stage 0, cascade-write at stage 1
   always_ff @(posedge clk) begin
      if (in_xfer) begin
         rd0 <= lb0[cur_col[AW-1:0]];
         rd1 <= lb1[cur_col[AW-1:0]];
      end
      if (s1_adv) begin
         lb0[s1_col[AW-1:0]] <= s1_pixel;
         lb1[s1_col[AW-1:0]] <= rd0;
      end
   end

   always_comb begin
      win_next = out_win;
      for (int r = 0; r < 3; r++) begin
         win_next[DATA_W*(3*r) +: DATA_W]   = out_win[DATA_W*(3*r+1) +: DATA_W];
         win_next[DATA_W*(3*r+1) +: DATA_W] = out_win[DATA_W*(3*r+2) +: DATA_W];
      end
      win_next[DATA_W*2 +: DATA_W] = rd1;
      win_next[DATA_W*5 +: DATA_W] = rd0;
      win_next[DATA_W*8 +: DATA_W] = s1_pixel;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_win   <= '0;
         out_col   <= '0;
         out_row   <= '0;
      end else if (s1_adv) begin
         out_valid <= s1_emit;
         out_last  <= s1_emit & s1_last;
         out_win   <= win_next;
         out_col   <= s1_col - ONE;
         out_row   <= s1_row - ONE;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_line_window_3x3.sv
// Bench for line_window_3x3: a 4x4 instance for the scenario tests and a
// default 72x72 instance for back-to-back full frames.
module tb_line_window_3x3;

   localparam int DW  = 8;
   localparam int SLW = 4;
   localparam int SFH = 4;
   localparam int CW  = 7;
   localparam int BLW = 72;
   localparam int BFH = 72;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int ncyc = 0;
   always @(posedge clk) ncyc <= ncyc + 1;

   int errors = 0;
   int checks = 0;

   logic            s_valid = 1'b0, s_ready, s_oready = 1'b1;
   logic [DW-1:0]   s_pixel = '0;
   logic            s_ovalid, s_last;
   logic [9*DW-1:0] s_win;
   logic [CW-1:0]   s_col, s_row;

   logic            b_valid = 1'b0, b_ready, b_oready = 1'b1;
   logic [DW-1:0]   b_pixel = '0;
   logic            b_ovalid, b_last;
   logic [9*DW-1:0] b_win;
   logic [CW-1:0]   b_col, b_row;

`ifdef LINE_WINDOW_SOF_EN
   logic s_sof = 1'b0;
   logic b_sof = 1'b0;
`endif

   line_window_3x3 #(
      .DATA_W(DW), .LINE_WIDTH(SLW), .FRAME_HEIGHT(SFH), .COL_W(CW)
   ) u_small (
      .clk(clk), .reset(reset),
      .in_valid(s_valid), .in_ready(s_ready), .in_pixel(s_pixel),
`ifdef LINE_WINDOW_SOF_EN
      .in_sof(s_sof),
`endif
      .out_valid(s_ovalid), .out_ready(s_oready), .out_win(s_win),
      .out_col(s_col), .out_row(s_row), .out_last(s_last)
   );

   line_window_3x3 u_big (
      .clk(clk), .reset(reset),
      .in_valid(b_valid), .in_ready(b_ready), .in_pixel(b_pixel),
`ifdef LINE_WINDOW_SOF_EN
      .in_sof(b_sof),
`endif
      .out_valid(b_ovalid), .out_ready(b_oready), .out_win(b_win),
      .out_col(b_col), .out_row(b_row), .out_last(b_last)
   );

   logic [DW-1:0]   stream [0:63];
   int              acc_cyc[$];
   logic [9*DW-1:0] o_win[$];
   int              o_row[$], o_col[$], o_last[$], o_cyc[$];
   logic [9*DW-1:0] bo_win[$];
   int              bo_row[$], bo_col[$], bo_last[$];

   // Record every window handed over at the following rising edge
   always @(negedge clk) begin
      if (!reset && s_ovalid && s_oready) begin
         o_win.push_back(s_win);
         o_row.push_back(int'(s_row));
         o_col.push_back(int'(s_col));
         o_last.push_back(int'(s_last));
         o_cyc.push_back(ncyc);
      end
      if (!reset && b_ovalid && b_oready) begin
         bo_win.push_back(b_win);
         bo_row.push_back(int'(b_row));
         bo_col.push_back(int'(b_col));
         bo_last.push_back(int'(b_last));
      end
   end

   // Reference window: 3x3 neighbourhood around (r,c) of a 4x4 frame at base
   function automatic logic [9*DW-1:0] exp_win(int base, int r, int c);
      logic [9*DW-1:0] w;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[DW*(3*i+j) +: DW] = stream[base + (r-1+i)*SLW + (c-1+j)];
      return w;
   endfunction

   function automatic logic [DW-1:0] bpix(int f, int r, int c);
      return DW'(f ^ r ^ c);
   endfunction

   task automatic clear_obs();
      acc_cyc.delete();
      o_win.delete(); o_row.delete(); o_col.delete();
      o_last.delete(); o_cyc.delete();
      bo_win.delete(); bo_row.delete(); bo_col.delete(); bo_last.delete();
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      b_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      clear_obs();
   endtask

   task automatic drain();
      repeat (8) @(posedge clk);
      #1;
   endtask

   // gap: 0 = continuous, 1 = valid toggles every cycle, 2 = random
   task automatic drive_small(input int n, input int gap, input int sof_at,
                              output int sent);
      int  k = 0;
      int  lim = 0;
      bit  ph = 1'b0;
      while (k < n && lim < 2000) begin
         ph = ~ph;
         s_valid = (gap == 0) ? 1'b1 :
                   (gap == 1) ? ph : 1'($urandom_range(0, 1));
         s_pixel = stream[k];
`ifdef LINE_WINDOW_SOF_EN
         s_sof = (k == sof_at) || (!s_valid && sof_at >= 0);
`endif
         @(negedge clk);
         if (s_valid && s_ready) begin
            acc_cyc.push_back(ncyc);
            k++;
         end
         @(posedge clk);
         #1 lim++;
      end
      s_valid = 1'b0;
`ifdef LINE_WINDOW_SOF_EN
      s_sof = 1'b0;
`endif
      sent = k;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      s_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0) begin
         errors++; $display("FAIL reset_in_ready got=%b want=0", s_ready);
      end
      checks++;
      if (s_ovalid !== 1'b0 || b_ovalid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got=%b/%b want=0", s_ovalid, b_ovalid);
      end
      checks++;
      if (s_win !== '0) begin
         errors++; $display("FAIL reset_out_win got=%h want=0", s_win);
      end
      checks++;
      if (s_col !== '0 || s_row !== '0 || s_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_coords got=%0d,%0d,%b want=0,0,0", s_row, s_col, s_last);
      end
      s_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1) begin
         errors++; $display("FAIL after_reset_in_ready got=%b want=1", s_ready);
      end
      clear_obs();
   endtask

   task automatic check_four(input string nm, input int base);
      for (int k = 0; k < 4; k++) begin
         if (k < o_win.size()) begin
            checks++;
            if (o_win[k] !== exp_win(base, 1 + k/2, 1 + k%2)) begin
               errors++;
               $display("FAIL %s_win%0d got=%h want=%h", nm, k, o_win[k],
                        exp_win(base, 1 + k/2, 1 + k%2));
            end
            checks++;
            if (o_row[k] != 1 + k/2 || o_col[k] != 1 + k%2 || o_last[k] != int'(k == 3)) begin
               errors++;
               $display("FAIL %s_pos%0d got=(%0d,%0d,last=%0d) want=(%0d,%0d,last=%0d)",
                        nm, k, o_row[k], o_col[k], o_last[k], 1 + k/2, 1 + k%2, int'(k == 3));
            end
         end
      end
   endtask

   task automatic test_basic();
      int sent;
      logic [9*DW-1:0] first;
      do_reset();
      for (int i = 0; i < 16; i++) stream[i] = DW'((i/4)*16 + i%4);
      s_oready = 1'b1;
      drive_small(16, 0, -1, sent);
      drain();
      checks++;
      if (sent != 16) begin
         errors++; $display("FAIL basic_sent got=%0d want=16", sent);
      end
      checks++;
      if (o_win.size() != 4) begin
         errors++; $display("FAIL basic_count got=%0d want=4", o_win.size());
      end
      check_four("basic", 0);
      first = 72'h222120121110020100;
      if (o_win.size() > 0 && acc_cyc.size() > 10) begin
         checks++;
         if (o_win[0] !== first) begin
            errors++; $display("FAIL basic_first got=%h want=%h", o_win[0], first);
         end
         checks++;
         if (o_cyc[0] - acc_cyc[10] != 2) begin
            errors++;
            $display("FAIL basic_latency got=%0d want=2", o_cyc[0] - acc_cyc[10]);
         end
      end
   endtask

   task automatic test_stall();
      int sent;
      int bad = 0;
      int w = 0;
      logic [9*DW-1:0] held;
      do_reset();
      for (int i = 0; i < 16; i++) stream[i] = DW'($urandom);
      s_oready = 1'b1;
      fork
         drive_small(16, 0, -1, sent);
         begin
            @(negedge clk);
            while (!s_ovalid && w < 200) begin
               @(negedge clk);
               w++;
            end
            @(posedge clk);
            #1 s_oready = 1'b0;
            @(negedge clk);
            held = s_win;
            checks++;
            if (s_ovalid !== 1'b1) begin
               errors++; $display("FAIL stall_valid got=%b want=1", s_ovalid);
            end
            for (int i = 1; i < 5; i++) begin
               @(negedge clk);
               if (i == 1) begin
                  checks++;
                  if (s_ready !== 1'b0) begin
                     errors++; $display("FAIL stall_in_ready got=%b want=0", s_ready);
                  end
               end
               if (s_win !== held || s_ovalid !== 1'b1) bad++;
            end
            checks++;
            if (bad != 0) begin
               errors++; $display("FAIL stall_hold got=%0d changes want=0", bad);
            end
            @(posedge clk);
            #1 s_oready = 1'b1;
         end
      join
      drain();
      checks++;
      if (sent != 16 || o_win.size() != 4) begin
         errors++;
         $display("FAIL stall_count got=%0d sent %0d windows want=16 sent 4 windows",
                  sent, o_win.size());
      end
      check_four("stall", 0);
   endtask

   task automatic test_gaps();
      int sent;
      do_reset();
      for (int i = 0; i < 16; i++) stream[i] = DW'((i/4)*16 + i%4);
      s_oready = 1'b1;
      drive_small(16, 1, -1, sent);
      drain();
      checks++;
      if (sent != 16 || o_win.size() != 4) begin
         errors++;
         $display("FAIL gaps_count got=%0d sent %0d windows want=16 sent 4 windows",
                  sent, o_win.size());
      end
      check_four("gaps", 0);
   endtask

   task automatic test_reset_mid();
      int sent;
      do_reset();
      for (int i = 0; i < 16; i++) stream[i] = DW'((i/4)*16 + i%4);
      s_oready = 1'b1;
      drive_small(10, 0, -1, sent);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0) begin
         errors++; $display("FAIL midreset_in_ready got=%b want=0", s_ready);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (s_ovalid !== 1'b0) begin
         errors++; $display("FAIL midreset_out_valid got=%b want=0", s_ovalid);
      end
      @(posedge clk);
      #1 clear_obs();
      for (int i = 0; i < 16; i++) stream[i] = DW'($urandom);
      drive_small(16, 0, -1, sent);
      drain();
      checks++;
      if (sent != 16 || o_win.size() != 4) begin
         errors++;
         $display("FAIL midreset_count got=%0d sent %0d windows want=16 sent 4 windows",
                  sent, o_win.size());
      end
      check_four("midreset", 0);
      if (o_win.size() > 0 && acc_cyc.size() > 10) begin
         checks++;
         if (o_cyc[0] - acc_cyc[10] != 2) begin
            errors++;
            $display("FAIL midreset_first got=%0d want=2", o_cyc[0] - acc_cyc[10]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n = 2 * BLW * BFH;
      int per = (BLW - 2) * (BFH - 2);
      int k = 0;
      int lim = 0;
      int bad = 0;
      int lastbad = 0;
      int f, r, c, idx;
      logic [9*DW-1:0] ew;
      do_reset();
      while (k < n && lim < 40000) begin
         f = k / (BLW*BFH);
         r = (k % (BLW*BFH)) / BLW;
         c = k % BLW;
         b_valid = 1'b1;
         b_pixel = bpix(f, r, c);
         b_oready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (b_ready) k++;
         @(posedge clk);
         #1 lim++;
      end
      b_valid = 1'b0;
      b_oready = 1'b1;
      drain();
      checks++;
      if (k != n) begin
         errors++; $display("FAIL b2b_sent got=%0d want=%0d", k, n);
      end
      checks++;
      if (bo_win.size() != 2*per) begin
         errors++; $display("FAIL b2b_count got=%0d want=%0d", bo_win.size(), 2*per);
      end
      for (int q = 0; q < bo_win.size() && q < 2*per; q++) begin
         f = q / per;
         idx = q % per;
         r = 1 + idx / (BLW - 2);
         c = 1 + idx % (BLW - 2);
         ew = '0;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               ew[DW*(3*i+j) +: DW] = bpix(f, r-1+i, c-1+j);
         if (bo_win[q] !== ew || bo_row[q] != r || bo_col[q] != c) bad++;
         if (bo_last[q] != int'(idx == per - 1)) lastbad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL b2b_windows got=%0d wrong want=0", bad);
      end
      checks++;
      if (lastbad != 0) begin
         errors++; $display("FAIL b2b_last got=%0d misplaced want=0", lastbad);
      end
   endtask

`ifdef LINE_WINDOW_SOF_EN
   task automatic test_sof();
      int sent;
      do_reset();
      for (int i = 0; i < 23; i++) stream[i] = DW'($urandom);
      s_oready = 1'b1;
      drive_small(23, 1, 7, sent);
      drain();
      checks++;
      if (sent != 23 || o_win.size() != 4) begin
         errors++;
         $display("FAIL sof_count got=%0d sent %0d windows want=23 sent 4 windows",
                  sent, o_win.size());
      end
      check_four("sof", 7);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_gaps();
      test_reset_mid();
      test_back_to_back();
`ifdef LINE_WINDOW_SOF_EN
      test_sof();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
